// File: rtl/vga_tile_framebuffer.sv
// Tile colour store for the 640x480 VGA path: one 3-bit colour per 8x8 tile,
// host tile writes, a whole-buffer fill engine and a 2-cycle beam lookup.
module vga_tile_framebuffer #(
  parameter int H_TILES    = 80,
  parameter int V_TILES    = 60,
  parameter int TILE_SHIFT = 3
) (
  input  logic       CLK_25MH,
  input  logic       RST,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  output logic [2:0] RGBout,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_x,
  input  logic [5:0] wr_y,
  input  logic [2:0] wr_color,
  input  logic       clr_req,
  input  logic [2:0] clr_color,
  output logic       busy
);

  localparam int          NTILES = H_TILES * V_TILES;
  localparam logic [12:0] LAST   = 13'(NTILES - 1);
  localparam logic [9:0]  H_ACT  = 10'(H_TILES << TILE_SHIFT);
  localparam logic [9:0]  V_ACT  = 10'(V_TILES << TILE_SHIFT);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  // Row stride of 80 tiles is built as 64 + 16 so no multiplier is needed.
  function automatic logic [12:0] tile_addr(input logic [6:0] x, input logic [5:0] y);
    return ({7'd0, y} << 6) + ({7'd0, y} << 4) + {6'd0, x};
  endfunction

  logic [2:0]  r_mem [0:NTILES-1];

  state_t      r_state, w_state_nx;
  logic [12:0] r_ptr, w_ptr_nx;
  logic [2:0]  r_fill_col, w_fill_col_nx;

  logic        r_active;
  logic [12:0] r_raddr;

  logic        w_active;
  logic [6:0]  w_hx;
  logic [5:0]  w_vy;
  logic        w_host_we;
  logic        w_we;
  logic [12:0] w_waddr;
  logic [2:0]  w_wdata;
  logic        w_unused_ok;

  assign busy     = (r_state == S_FILL);
  assign wr_ready = !busy;

  // Fill engine
  always_ff @(posedge CLK_25MH or posedge RST) begin
    if (RST) begin
      r_state    <= S_FILL;
      r_ptr      <= '0;
      r_fill_col <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_ptr      <= w_ptr_nx;
      r_fill_col <= w_fill_col_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_ptr_nx      = r_ptr;
    w_fill_col_nx = r_fill_col;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_nx    = S_FILL;
          w_ptr_nx      = '0;
          w_fill_col_nx = clr_color;
        end
      end
      S_FILL: begin
        if (r_ptr == LAST) begin
          w_state_nx = S_IDLE;
          w_ptr_nx   = '0;
        end else begin
          w_ptr_nx = r_ptr + 13'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Single write port: fill and host are mutually exclusive via wr_ready.
  assign w_host_we = wr_valid && wr_ready &&
                     (wr_x < 7'(H_TILES)) && (wr_y < 6'(V_TILES));
  assign w_we      = busy || w_host_we;
  assign w_waddr   = busy ? r_ptr : tile_addr(wr_x, wr_y);
  assign w_wdata   = busy ? r_fill_col : wr_color;

  always_ff @(posedge CLK_25MH) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Beam lookup; blanking positions are steered to address 0 and masked later.
  assign w_active = (hcount < H_ACT) && (vcount < V_ACT);
  assign w_hx     = hcount[TILE_SHIFT +: 7];
  assign w_vy     = vcount[TILE_SHIFT +: 6];

  always_ff @(posedge CLK_25MH or posedge RST) begin
    if (RST) begin
      r_active <= 1'b0;
      r_raddr  <= '0;
      RGBout   <= 3'b000;
    end else begin
      r_active <= w_active;
      r_raddr  <= w_active ? tile_addr(w_hx, w_vy) : 13'd0;
      RGBout   <= r_active ? r_mem[r_raddr] : 3'b000;
    end
  end

  assign w_unused_ok = ^{hcount[TILE_SHIFT-1:0], vcount[TILE_SHIFT-1:0]};

endmodule

// File: tb/tb_vga_tile_framebuffer.sv
// Directed bench for vga_tile_framebuffer: vector tables for pixel lookups,
// hand sequences for fill timing, collisions and mid-fill reset.
module tb_vga_tile_framebuffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hcount, vcount;
  logic [2:0] RGBout;
  logic       wr_valid, wr_ready;
  logic [6:0] wr_x;
  logic [5:0] wr_y;
  logic [2:0] wr_color;
  logic       clr_req;
  logic [2:0] clr_color;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [2:0] model [0:4799];

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic [2:0] exp;
  } vec_t;

  vec_t tab [$];

  vga_tile_framebuffer dut (
    .CLK_25MH (clk),
    .RST      (rst),
    .hcount   (hcount),
    .vcount   (vcount),
    .RGBout   (RGBout),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_color (wr_color),
    .clr_req  (clr_req),
    .clr_color(clr_color),
    .busy     (busy)
  );

  always #20 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic model_fill(input logic [2:0] c);
    for (int i = 0; i < 4800; i++) model[i] = c;
  endtask

  task automatic apply_vec(input vec_t t);
    @(negedge clk);
    hcount = t.h;
    vcount = t.v;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("pix h=%0d v=%0d", t.h, t.v), int'(RGBout), int'(t.exp));
  endtask

  task automatic host_write(input int x, input int y, input logic [2:0] c);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_x     = 7'(x);
    wr_y     = 6'(y);
    wr_color = c;
    chk($sformatf("wr_ready x=%0d y=%0d", x, y), int'(wr_ready), 1);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    if (x < 80 && y < 60) model[y*80 + x] = c;
  endtask

  // Called at a negedge where busy should already be high; counts busy cycles.
  task automatic wait_fill(input string name, input int inj);
    int n   = 0;
    int bad = 0;
    for (int k = 0; k < 6000; k++) begin
      if (!busy) break;
      n++;
      if (wr_ready) bad++;
      if (inj > 0 && n == inj) begin
        clr_req   = 1'b1;
        clr_color = 3'b110;
      end else begin
        clr_req = 1'b0;
      end
      @(negedge clk);
    end
    clr_req = 1'b0;
    chk({name, " busy cycles"}, n, 4800);
    chk({name, " wr_ready high in fill"}, bad, 0);
    chk({name, " wr_ready after fill"}, int'(wr_ready), 1);
  endtask

  // One pixel per tile, pipelined at one position per cycle.
  task automatic sweep(input string name);
    int bad = 0;
    for (int i = 0; i < 4802; i++) begin
      @(negedge clk);
      if (i >= 2 && RGBout !== model[i-2]) bad++;
      if (i < 4800) begin
        hcount = 10'(((i % 80) * 8) + (i % 8));
        vcount = 10'(((i / 80) * 8) + ((i / 8) % 8));
      end
    end
    chk({name, " mismatching tiles"}, bad, 0);
  endtask

  initial begin
    rst = 1'b1; hcount = '0; vcount = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    clr_req = 1'b0; clr_color = '0;

    repeat (2) @(negedge clk);
    chk("reset RGBout", int'(RGBout), 0);
    chk("reset busy", int'(busy), 1);
    chk("reset wr_ready", int'(wr_ready), 0);
    rst = 1'b0;
    wait_fill("reset fill", 0);
    model_fill(3'b000);
    sweep("post-reset sweep");

    // Single tile write and its neighbours
    host_write(5, 2, 3'b101);
    for (int v = 16; v <= 23; v++)
      for (int h = 39; h <= 48; h++)
        tab.push_back('{10'(h), 10'(v), (h >= 40 && h <= 47) ? 3'b101 : 3'b000});
    tab.push_back('{10'd700, 10'd20,  3'b000});
    tab.push_back('{10'd44,  10'd500, 3'b000});
    for (int i = 0; i < tab.size(); i++) apply_vec(tab[i]);

    // Out-of-range writes handshake but must not land anywhere
    host_write(80, 10, 3'b111);
    host_write(3, 60, 3'b111);
    sweep("out-of-range sweep");

    // Read and write of tile (10,10) in the same cycle
    @(negedge clk);
    hcount = 10'd80; vcount = 10'd80;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b1; wr_x = 7'd10; wr_y = 6'd10; wr_color = 3'b110;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("same-cycle read old", int'(RGBout), int'(model[810]));
    @(posedge clk);
    @(negedge clk);
    chk("same-cycle read new", int'(RGBout), 6);
    model[810] = 3'b110;

    // Clear to 011 with an ignored re-request mid-fill
    @(negedge clk);
    clr_req = 1'b1; clr_color = 3'b011;
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0;
    wait_fill("clear 011", 100);
    model_fill(3'b011);
    sweep("clear sweep");
    tab.delete();
    tab.push_back('{10'd0,   10'd0,   3'b011});
    tab.push_back('{10'd639, 10'd479, 3'b011});
    tab.push_back('{10'd640, 10'd0,   3'b000});
    tab.push_back('{10'd700, 10'd100, 3'b000});
    tab.push_back('{10'd100, 10'd500, 3'b000});
    tab.push_back('{10'd799, 10'd524, 3'b000});
    for (int i = 0; i < tab.size(); i++) apply_vec(tab[i]);

    // Clear and host write together: the write is taken, then overwritten
    @(negedge clk);
    clr_req = 1'b1; clr_color = 3'b010;
    wr_valid = 1'b1; wr_x = 7'd0; wr_y = 6'd0; wr_color = 3'b111;
    chk("collision wr_ready", int'(wr_ready), 1);
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0; wr_valid = 1'b0;
    wait_fill("clear 010", 0);
    model_fill(3'b010);
    apply_vec('{10'd0, 10'd0, 3'b010});
    apply_vec('{10'd8, 10'd0, 3'b010});

    // Reset at fill pointer 2000
    @(negedge clk);
    clr_req = 1'b1; clr_color = 3'b101;
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0; hcount = 10'd0; vcount = 10'd0;
    repeat (2000) @(posedge clk);
    @(negedge clk);
    chk("mid-fill tile 0", int'(RGBout), 5);
    chk("mid-fill busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("async reset RGBout", int'(RGBout), 0);
    chk("async reset busy", int'(busy), 1);
    chk("async reset wr_ready", int'(wr_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_fill("refill after reset", 0);
    model_fill(3'b000);
    sweep("post-refill sweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
